// File: rtl/pipe_pkg.sv
// Shared types for the RV32 pipeline sequencing controller: FSM state encoding
// and register-index width.
package pipe_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalting = 2'd2,
    StHalted  = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> sequencing-controller bundle. The master side is the controller
// (drives enables/strobes); the slave side is the pipeline datapath.
interface pipe_ctrl_if;
  import pipe_pkg::*;

  logic               fetch_valid_F;
  logic [RegIdxW-1:0] rs1_D;
  logic [RegIdxW-1:0] rs2_D;
  logic               use_rs1_D;
  logic               use_rs2_D;
  logic [RegIdxW-1:0] rd_E;
  logic               memread_E;
  logic               branch_taken_E;
  logic               mem_req_M;
  logic               mem_ack_M;
  logic               halt_req;
  logic               resume;

  logic               stall_F;
  logic               valid_D;
  logic               valid_E;
  logic               valid_M;
  logic               flash_D;
  logic               flash_E;
  logic               retire_W;
  logic               halted;
  logic               mem_err;
  logic [31:0]        perf_stall;
  logic [31:0]        perf_flush;

  modport master (
    input  fetch_valid_F, rs1_D, rs2_D, use_rs1_D, use_rs2_D, rd_E, memread_E,
           branch_taken_E, mem_req_M, mem_ack_M, halt_req, resume,
    output stall_F, valid_D, valid_E, valid_M, flash_D, flash_E, retire_W, halted,
           mem_err, perf_stall, perf_flush
  );

  modport slave (
    output fetch_valid_F, rs1_D, rs2_D, use_rs1_D, use_rs2_D, rd_E, memread_E,
           branch_taken_E, mem_req_M, mem_ack_M, halt_req, resume,
    input  stall_F, valid_D, valid_E, valid_M, flash_D, flash_E, retire_W, halted,
           mem_err, perf_stall, perf_flush
  );

endinterface

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use dependency (D on a load in E) and
// taken-branch redirect from E.
module hazard_unit import pipe_pkg::*; (
  input  logic               occ_D,
  input  logic               occ_E,
  input  logic [RegIdxW-1:0] rs1_D,
  input  logic [RegIdxW-1:0] rs2_D,
  input  logic               use_rs1_D,
  input  logic               use_rs2_D,
  input  logic [RegIdxW-1:0] rd_E,
  input  logic               memread_E,
  input  logic               branch_taken_E,
  output logic               lu,
  output logic               br
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = use_rs1_D & (rs1_D == rd_E);
    rs2_hit = use_rs2_D & (rs2_D == rd_E);
    // x0 is never a real dependency
    lu      = occ_D & occ_E & memread_E & (rd_E != '0) & (rs1_hit | rs2_hit);
    br      = occ_E & branch_taken_E;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencing controller: occupancy tracking, stage enables,
// bubble strobes, memory-wait timeout and halt/drain. Optional perf counters
// are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl import pipe_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] WaitLast = TO_W'(MEM_TIMEOUT - 1);

  pipe_state_e     state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            occ_dec_q, occ_dec_d;
  logic            occ_exe_q, occ_exe_d;
  logic            occ_mem_q, occ_mem_d;
  logic            occ_wb_q, occ_wb_d;

  logic lu;
  logic br;
  logic timeout;
  logic ack_ok;
  logic mem_stall;
  logic hold;
  logic drain;
  logic stall_f;

  hazard_unit u_hazard (
    .occ_D          (occ_dec_q),
    .occ_E          (occ_exe_q),
    .rs1_D          (bus.rs1_D),
    .rs2_D          (bus.rs2_D),
    .use_rs1_D      (bus.use_rs1_D),
    .use_rs2_D      (bus.use_rs2_D),
    .rd_E           (bus.rd_E),
    .memread_E      (bus.memread_E),
    .branch_taken_E (bus.branch_taken_E),
    .lu             (lu),
    .br             (br)
  );

  always_comb begin
    timeout   = (state_q == StMemWait) && (wait_cnt_q == WaitLast);
    ack_ok    = bus.mem_ack_M | timeout;
    mem_stall = occ_mem_q & bus.mem_req_M & ~ack_ok;
    hold      = (state_q == StHalted) | mem_stall;
    drain     = (state_q == StHalting) | ((state_q == StRun) & bus.halt_req);
  end

  // Occupancy only moves when the pipeline advances; br outranks lu.
  always_comb begin
    occ_dec_d = occ_dec_q;
    occ_exe_d = occ_exe_q;
    occ_mem_d = occ_mem_q;
    occ_wb_d  = occ_wb_q;
    if (!hold) begin
      occ_wb_d  = occ_mem_q;
      occ_mem_d = occ_exe_q;
      occ_exe_d = (br | lu) ? 1'b0 : occ_dec_q;
      if (br | drain) begin
        occ_dec_d = 1'b0;
      end else if (lu) begin
        occ_dec_d = occ_dec_q;
      end else begin
        occ_dec_d = bus.fetch_valid_F;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (bus.halt_req) begin
          state_d = StHalting;
        end
      end
      StMemWait: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (ack_ok) begin
          state_d = StRun;
          if (!bus.mem_ack_M) begin
            mem_err_d = 1'b1;
          end
        end
      end
      StHalting: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (!(occ_dec_d | occ_exe_d | occ_mem_d | occ_wb_d)) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (bus.resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      occ_dec_q  <= 1'b0;
      occ_exe_q  <= 1'b0;
      occ_mem_q  <= 1'b0;
      occ_wb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      occ_dec_q  <= occ_dec_d;
      occ_exe_q  <= occ_exe_d;
      occ_mem_q  <= occ_mem_d;
      occ_wb_q   <= occ_wb_d;
    end
  end

  // Reset forces the quiescent pattern: everything held, no strobes.
  always_comb begin
    stall_f      = 1'b1;
    bus.valid_D  = 1'b0;
    bus.valid_E  = 1'b0;
    bus.valid_M  = 1'b0;
    bus.flash_D  = 1'b0;
    bus.flash_E  = 1'b0;
    bus.retire_W = 1'b0;
    bus.halted   = 1'b0;
    if (!rst) begin
      stall_f      = hold | drain | (lu & ~br);
      bus.valid_D  = ~hold;
      bus.valid_E  = ~hold;
      bus.valid_M  = ~hold;
      bus.flash_D  = ~hold & (br | drain);
      bus.flash_E  = ~hold & (br | lu);
      bus.retire_W = occ_wb_q & (state_q != StHalted);
      bus.halted   = (state_q == StHalted);
    end
  end

  assign bus.stall_F = stall_f;
  assign bus.mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_f) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (br & ~hold) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a stage-by-stage instruction-id model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int unsigned Timeout = 4;
  localparam int ModeRun     = 0;
  localparam int ModeWait    = 1;
  localparam int ModeHalting = 2;
  localparam int ModeHalted  = 3;

  typedef struct packed {
    logic       rst;
    logic       fetch;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       memread;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       halt_req;
    logic       resume;
  } stim_t;

  typedef struct packed {
    logic        stall_F;
    logic        valid_D;
    logic        valid_E;
    logic        valid_M;
    logic        flash_D;
    logic        flash_E;
    logic        retire_W;
    logic        halted;
    logic        mem_err;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
  } obs_t;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MEM_TIMEOUT (Timeout),
    .TO_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: instruction ids per stage (0 = empty), D, E, M, W.
  int          stage[4];
  int          mode;
  int          waited;
  bit          err_m;
  int          next_id;
  logic [31:0] perf_stall_m;
  logic [31:0] perf_flush_m;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) stage[i] = 0;
    mode         = ModeRun;
    waited       = 0;
    err_m        = 1'b0;
    perf_stall_m = '0;
    perf_flush_m = '0;
  endfunction

  function automatic void calc(input stim_t s, output bit lu, output bit br,
                               output bit hold, output bit drain);
    bit dep;
    bit forced;
    dep    = (s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd);
    lu     = stage[0] != 0 && stage[1] != 0 && s.memread && s.rd != 0 && dep;
    br     = stage[1] != 0 && s.br_taken;
    forced = mode == ModeWait && waited == int'(Timeout) - 1;
    hold   = mode == ModeHalted || (stage[2] != 0 && s.mem_req && !s.mem_ack && !forced);
    drain  = mode == ModeHalting || (mode == ModeRun && s.halt_req);
  endfunction

  function automatic obs_t predict(input stim_t s);
    obs_t o;
    bit lu, br, hold, drain;
    calc(s, lu, br, hold, drain);
    o         = '0;
    o.stall_F = 1'b1;
    o.mem_err = err_m;
`ifdef PIPE_CTRL_PERF_EN
    o.perf_stall = perf_stall_m;
    o.perf_flush = perf_flush_m;
`endif
    if (!s.rst) begin
      o.valid_D  = !hold;
      o.valid_E  = !hold;
      o.valid_M  = !hold;
      o.flash_D  = !hold && (br || drain);
      o.flash_E  = !hold && (br || lu);
      o.stall_F  = hold || drain || (lu && !br);
      o.retire_W = stage[3] != 0 && mode != ModeHalted;
      o.halted   = mode == ModeHalted;
    end
    return o;
  endfunction

  function automatic void advance(input stim_t s, input obs_t e);
    bit lu, br, hold, drain, mstall;
    int nxt[4];
    if (s.rst) begin
      model_reset();
      return;
    end
    calc(s, lu, br, hold, drain);
    if (e.stall_F) perf_stall_m = perf_stall_m + 1;
    if (br && !hold) perf_flush_m = perf_flush_m + 1;
    nxt = stage;
    if (!hold) begin
      nxt[3] = stage[2];
      nxt[2] = stage[1];
      nxt[1] = (br || lu) ? 0 : stage[0];
      if (br || drain) nxt[0] = 0;
      else if (lu) nxt[0] = stage[0];
      else if (s.fetch) begin
        next_id = next_id + 1;
        nxt[0]  = next_id;
      end else nxt[0] = 0;
    end
    mstall = stage[2] != 0 && s.mem_req && !s.mem_ack;
    case (mode)
      ModeRun: begin
        if (mstall) begin
          mode   = ModeWait;
          waited = 0;
        end else if (s.halt_req) mode = ModeHalting;
      end
      ModeWait: begin
        if (s.mem_ack) mode = ModeRun;
        else if (waited == int'(Timeout) - 1) begin
          err_m = 1'b1;
          mode  = ModeRun;
        end else waited = waited + 1;
      end
      ModeHalting: begin
        if (mstall) begin
          mode   = ModeWait;
          waited = 0;
        end else if (nxt[0] == 0 && nxt[1] == 0 && nxt[2] == 0 && nxt[3] == 0) begin
          mode = ModeHalted;
        end
      end
      default: if (s.resume) mode = ModeRun;
    endcase
    stage = nxt;
  endfunction

  task automatic drive(input stim_t s);
    rst                = s.rst;
    bus.fetch_valid_F  = s.fetch;
    bus.rs1_D          = s.rs1;
    bus.rs2_D          = s.rs2;
    bus.use_rs1_D      = s.use1;
    bus.use_rs2_D      = s.use2;
    bus.rd_E           = s.rd;
    bus.memread_E      = s.memread;
    bus.branch_taken_E = s.br_taken;
    bus.mem_req_M      = s.mem_req;
    bus.mem_ack_M      = s.mem_ack;
    bus.halt_req       = s.halt_req;
    bus.resume         = s.resume;
  endtask

  task automatic step(input stim_t s);
    obs_t e;
    drive(s);
    if (s.rst) model_reset();
    e = predict(s);
    exp_q.push_back(e);
    @(posedge clk);
    advance(s, e);
    #1;
  endtask

  task automatic steps(input stim_t s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  // Monitor: one expected entry per cycle, compared on the falling edge.
  initial begin
    obs_t got;
    obs_t want;
    int   cyc;
    cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {bus.stall_F, bus.valid_D, bus.valid_E, bus.valid_M, bus.flash_D,
                bus.flash_E, bus.retire_W, bus.halted, bus.mem_err, bus.perf_stall,
                bus.perf_flush};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h required %h (stall,vD,vE,vM,fD,fE,ret,halt,err,ps,pf)",
                   cyc, got, want);
        end
      end
      cyc++;
    end
  end

  initial begin
    stim_t s;
    stim_t z;
    bit    halt_lvl;
    next_id = 0;
    model_reset();
    z = '0;
    s = z;
    s.rst = 1'b1;
    drive(s);
    @(posedge clk);
    #1;

    steps(s, 3);
    // Straight-line fetch, then drain.
    s = z; s.fetch = 1'b1; steps(s, 5);
    s = z; steps(s, 4);

    // Load-use on x5 with D reading rs1.
    s = z; s.fetch = 1'b1; steps(s, 2);
    s.memread = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1; step(s);
    s = z; s.fetch = 1'b1; steps(s, 2);
    s = z; steps(s, 4);

    // Branch and load-use together.
    s = z; s.fetch = 1'b1; steps(s, 2);
    s.memread = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.use2 = 1'b1; s.br_taken = 1'b1; step(s);
    s = z; s.fetch = 1'b1; step(s);
    s = z; steps(s, 4);

    // Memory wait acknowledged after 3 held cycles.
    s = z; s.fetch = 1'b1; steps(s, 3);
    s = z; s.mem_req = 1'b1; steps(s, 3);
    s.mem_ack = 1'b1; step(s);
    s = z; steps(s, 4);

    // Memory timeout: one instruction, never acknowledged.
    s = z; s.fetch = 1'b1; step(s);
    s = z; steps(s, 2);
    s.mem_req = 1'b1; steps(s, 5);
    s = z; steps(s, 4);

    // Reset in the middle of a memory wait.
    s = z; s.rst = 1'b1; steps(s, 2);
    s = z; s.fetch = 1'b1; step(s);
    s = z; steps(s, 2);
    s.mem_req = 1'b1; steps(s, 2);
    s.rst = 1'b1; step(s);
    s = z; steps(s, 3);

    // Halt with three in flight, then resume.
    s = z; s.fetch = 1'b1; steps(s, 3);
    s.halt_req = 1'b1; steps(s, 7);
    s = z; steps(s, 3);
    s.resume = 1'b1; step(s);
    s = z; s.fetch = 1'b1; steps(s, 5);

    // Randomised traffic.
    halt_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      s          = z;
      s.rst      = ($urandom_range(0, 399) == 0);
      s.fetch    = ($urandom_range(0, 99) < 85);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.use1     = $urandom_range(0, 1) == 1;
      s.use2     = $urandom_range(0, 1) == 1;
      s.memread  = $urandom_range(0, 1) == 1;
      s.br_taken = ($urandom_range(0, 99) < 15);
      s.mem_req  = (mode == ModeWait) || ($urandom_range(0, 99) < 40);
      s.mem_ack  = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 3) halt_lvl = ~halt_lvl;
      s.halt_req = halt_lvl;
      s.resume   = ($urandom_range(0, 99) < 20);
      step(s);
    end
    s = z; steps(s, 4);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
